instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 16-bit register-file/ALU datapath. It accepts one instruction word through a valid/ready handshake and latches it into an internal instruction register. It then steps the datapath through bus-source selection, the A/R register loads and the general-register writes over one to three execution cycles. It replaces the free-running step counter plus combinational control decode with a single FSM that exposes explicit `busy`, `done` and `illegal` status.

## Interface
Parameters:
- `W`, 16, instruction and immediate-extension width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr`  in  W  instruction word; sampled only on an accepted handshake.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction this cycle.
- `hold`  in  1  stall request; freezes the FSM.
- `bus_src`  out  4  bus source: 0–7 = R0–R7, 8 = regR, 9 = sign-extended imm[8:0], 15 = none.
- `gpr_wen`  out  8  one-hot general-register write enable.
- `a_wen`  out  1  regA load.
- `r_wen`  out  1  regR load.
- `alu_op`  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse in the final execution cycle of a legal instruction.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
Instruction format:
- opcode = [15:12]
- Rx = [11:9]
- Ry = [8:6]
- imm = [8:0]; only MVI uses this field, and it overlaps Ry.

Opcodes:
- 0 MV
- 1 MVI
- 2 ADD
- 3 SUB
- 4 AND
- 5 OR
- 6–15 illegal

FSM states: IDLE, T1, T2, T3. All control outputs are Moore outputs, decoded from the state and the instruction register (IR).
- IDLE: `instr_ready`=1, `bus_src`=15, all enables 0. When `instr_valid`=1 and `hold`=0, load IR and go to T1.
- T1, MV: `bus_src`=Ry, `gpr_wen[Rx]`=1, `done`=1, then IDLE.
- T1, MVI: `bus_src`=9, `gpr_wen[Rx]`=1, `done`=1, then IDLE.
- T1, ALU ops: `bus_src`=Rx, `a_wen`=1, then T2.
- T1, illegal: `illegal`=1, no enables, then IDLE.
- T2: `bus_src`=Ry, `alu_op` from opcode, `r_wen`=1, then T3.
- T3: `bus_src`=8, `gpr_wen[Rx]`=1, `done`=1, then IDLE.
- `alu_op` holds its decoded value in T2 and T3 and is 00 elsewhere.

Boundary conditions:
- Rx == Ry is legal; the sequence is unchanged, because regA is captured in T1 before the T3 writeback.
- `hold`=1 in IDLE: `instr_ready`=0 and nothing is accepted.
- `hold`=1 in T1–T3: state and IR are frozen, `bus_src` keeps its value, all enables, `done` and `illegal` are forced to 0. The same step re-issues when `hold` falls.
- `instr` is ignored outside an accepted handshake, so changes to it mid-instruction have no effect.
- `reset` asserted at any time: state goes to IDLE and IR to 0 immediately (asynchronously), all enables drop in the same cycle, and no partial writeback completes.

## Timing
Reset values:
- `instr_ready`=1, `busy`=0, `bus_src`=15.
- `gpr_wen`=0, `a_wen`=0, `r_wen`=0, `alu_op`=00, `done`=0, `illegal`=0.
- IR = 0.

Handshake and cycle timing:
- Accept happens at the rising edge where `instr_valid` & `instr_ready`.
- Execution cycles without `hold`: MV, MVI and illegal take 1 cycle; ALU ops take 3.
- The write commits at the rising edge that ends the `done` cycle.
- `instr_ready` rises in the cycle after `done` or `illegal`. Back-to-back MV therefore issues one instruction every 2 cycles, and ALU ops one every 4.
- `busy` = 1 exactly in T1–T3.

## Structure
- Package `seq_pkg` holds:
  - opcode constants `OP_MV`..`OP_OR`;
  - the state enum (IDLE/T1/T2/T3, 2-bit);
  - bus source codes `SRC_R0`, `SRC_R`=8, `SRC_IMM`=9, `SRC_NONE`=15;
  - ALU op codes.
- Sub-module `onehot_dec3`: a 3-to-8 one-hot decoder with enable, used to produce `gpr_wen` from Rx.

## Test plan
- Reset release, then MVI R3,#0x1FF: accepted at edge 1. Next cycle: `bus_src`=9, `gpr_wen`=0x08, `done`=1. `instr_ready`=1 one cycle later.
- ADD R1,R2 with no hold. Required sequence over T1/T2/T3:
  - `bus_src` 1 / 2 / 8;
  - `a_wen`, then `r_wen` with `alu_op`=00, then `gpr_wen`=0x02 with `done`=1;
  - `busy`=1 for exactly 3 cycles.
- SUB R4,R4 with `hold`=1 for 2 cycles during T2: T2 outputs persist, `r_wen`=0 while held, then `r_wen`=1 for 1 cycle, then T3 with `gpr_wen`=0x10. Total `busy`=5 cycles.
- Opcode 0xA: `illegal`=1 for 1 cycle with `done`=0 and all enables 0, then back to IDLE.
- `reset` driven low in T2 of an OR: enables drop immediately, with no `gpr_wen` pulse ever seen. After release: IDLE, `instr_ready`=1.
- `instr_valid` held high with MV instructions streaming: one accept every 2 cycles, and `instr` values changed during T1 are not sampled.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// bus-source codes and ALU operation codes, plus small decode helpers.
package seq_pkg;

  // Opcode field values, instr[15:12]
  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;

  // Sequencer states; T1..T3 are execution cycles
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  // Bus source selector codes; R0..R7 occupy 0..7
  localparam logic [3:0] SRC_R0   = 4'd0;
  localparam logic [3:0] SRC_R    = 4'd8;
  localparam logic [3:0] SRC_IMM  = 4'd9;
  localparam logic [3:0] SRC_NONE = 4'd15;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // True for the three-cycle register-register ALU instructions
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // ALU operation for an opcode; non-ALU opcodes map to add
  function automatic logic [1:0] alu_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction handshake and datapath control bundle for the sequencer.
// slave = sequencer side, master = instruction source / datapath side.
interface instr_sequencer_if #(
  parameter int W = 16
);
  logic [W-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         hold;
  logic [3:0]   bus_src;
  logic [7:0]   gpr_wen;
  logic         a_wen;
  logic         r_wen;
  logic [1:0]   alu_op;
  logic         busy;
  logic         done;
  logic         illegal;

  modport slave (
    input  instr, instr_valid, hold,
    output instr_ready, bus_src, gpr_wen, a_wen, r_wen, alu_op,
           busy, done, illegal
  );

  modport master (
    output instr, instr_valid, hold,
    input  instr_ready, bus_src, gpr_wen, a_wen, r_wen, alu_op,
           busy, done, illegal
  );
endinterface

// File: rtl/instr_sequencer_onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; drives general-register write strobes.
module onehot_dec3 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  assign y = en ? (8'd1 << sel) : 8'd0;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: latches one instruction through a
// valid/ready handshake, then steps the register-file/ALU datapath through
// one (MV, MVI, illegal) or three (ADD/SUB/AND/OR) execution cycles.
// All control outputs are Moore-decoded from state and IR; hold only masks
// the enables and pulses so a stalled step re-issues unchanged.
module instr_sequencer #(
  parameter int W = 16
) (
  input  logic             clock,
  input  logic             reset,
  instr_sequencer_if.slave bus
);
  import seq_pkg::*;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] ir;

  logic [3:0]   opcode;
  logic [2:0]   rx;
  logic [2:0]   ry;
  logic         run;
  logic         accept;

  logic         ready;
  logic         busy;
  logic [3:0]   src;
  logic         gpr_en;
  logic [7:0]   gpr_wen;
  logic         a_wen;
  logic         r_wen;
  logic [1:0]   alu_op;
  logic         done;
  logic         illegal;

  // Instruction fields; imm[8:0] is consumed by the datapath, not here
  assign opcode = ir[15:12];
  assign rx     = ir[11:9];
  assign ry     = ir[8:6];

  // Low bits only matter to the datapath's immediate extension
  logic ir_unused;
  assign ir_unused = ^ir[5:0];

  assign run    = ~bus.hold;
  assign accept = (state == IDLE) && bus.instr_valid && run;

  // State register and instruction register; IR loads only on accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ir <= bus.instr;
      end
    end
  end

  // Next-state decode; hold freezes the current step
  always_comb begin
    state_nx = state;
    if (run) begin
      case (state)
        IDLE:    if (bus.instr_valid) state_nx = T1;
        T1:      state_nx = is_alu(opcode) ? T2 : IDLE;
        T2:      state_nx = T3;
        T3:      state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Moore control decode; enables and pulses are masked while held
  always_comb begin
    ready   = 1'b0;
    busy    = 1'b1;
    src     = SRC_NONE;
    gpr_en  = 1'b0;
    a_wen   = 1'b0;
    r_wen   = 1'b0;
    alu_op  = ALU_ADD;
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        ready = run;
      end
      T1: begin
        if (opcode == OP_MV) begin
          src    = SRC_R0 + {1'b0, ry};
          gpr_en = run;
          done   = run;
        end else if (opcode == OP_MVI) begin
          src    = SRC_IMM;
          gpr_en = run;
          done   = run;
        end else if (is_alu(opcode)) begin
          // Capture the first operand in regA before any writeback to Rx
          src    = SRC_R0 + {1'b0, rx};
          a_wen  = run;
        end else begin
          illegal = run;
        end
      end
      T2: begin
        src    = SRC_R0 + {1'b0, ry};
        alu_op = alu_of(opcode);
        r_wen  = run;
      end
      T3: begin
        src    = SRC_R;
        alu_op = alu_of(opcode);
        gpr_en = run;
        done   = run;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  onehot_dec3 u_gpr_dec (
    .en  (gpr_en),
    .sel (rx),
    .y   (gpr_wen)
  );

  assign bus.instr_ready = ready;
  assign bus.busy        = busy;
  assign bus.bus_src     = src;
  assign bus.gpr_wen     = gpr_wen;
  assign bus.a_wen       = a_wen;
  assign bus.r_wen       = r_wen;
  assign bus.alu_op      = alu_op;
  assign bus.done        = done;
  assign bus.illegal     = illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-cycle expected control vectors
// and expected writebacks are queued as stimulus is driven, then popped and
// compared as the sequencer steps.
module tb_instr_sequencer;

  logic clock;
  logic reset;

  instr_sequencer_if #(.W(16)) bus ();

  instr_sequencer #(.W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // {ready, busy, bus_src[3:0], gpr_wen[7:0], a_wen, r_wen, alu_op[1:0], done, illegal}
  logic [19:0] obs;
  assign obs = {bus.instr_ready, bus.busy, bus.bus_src, bus.gpr_wen,
                bus.a_wen, bus.r_wen, bus.alu_op, bus.done, bus.illegal};

  logic [19:0] exp_q[$];
  logic [11:0] wb_q[$];
  logic [19:0] idle_v;

  logic watch_gw = 1'b0;
  logic gw_seen  = 1'b0;

  always @(negedge clock) begin
    if (watch_gw && (bus.gpr_wen !== 8'h00)) gw_seen = 1'b1;
  end

  function automatic logic [19:0] mk(input logic rdy, input logic bsy,
                                     input logic [3:0] src, input logic [7:0] gw,
                                     input logic aw, input logic rw,
                                     input logic [1:0] op, input logic dn,
                                     input logic il);
    return {rdy, bsy, src, gw, aw, rw, op, dn, il};
  endfunction

  task automatic drive(input logic v, input logic h, input logic [15:0] i);
    bus.instr_valid = v;
    bus.hold        = h;
    bus.instr       = i;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clock);
    #2;
    n_tests++;
    if (obs !== idle_v) begin
      n_fail++;
      $display("FAIL reset_held: got %05h required %05h", obs, idle_v);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== idle_v) begin
      n_fail++;
      $display("FAIL reset_release: got %05h required %05h", obs, idle_v);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_mvi();
    logic [19:0] e;
    exp_q.push_back(idle_v);
    exp_q.push_back(mk(1'b0, 1'b1, 4'd9, 8'h08, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(idle_v);
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 16'h17FF);
      else        drive(1'b0, 1'b0, 16'h0000);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mvi c%0d: got %05h required %05h", c, obs, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_add();
    logic [19:0] e;
    int busy_n = 0;
    exp_q.push_back(idle_v);
    exp_q.push_back(mk(1'b0, 1'b1, 4'd1, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd8, 8'h02, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(idle_v);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 16'h2280);
      else        drive(1'b0, 1'b0, 16'h0000);
      #1;
      if (bus.busy === 1'b1) busy_n++;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL add c%0d: got %05h required %05h", c, obs, e);
      end
      @(posedge clock);
      #1;
    end
    n_tests++;
    if (busy_n !== 3) begin
      n_fail++;
      $display("FAIL add_busy_cycles: got %0d required 3", busy_n);
    end
  endtask

  task automatic test_sub_hold();
    logic [19:0] e;
    int busy_n = 0;
    exp_q.push_back(idle_v);
    exp_q.push_back(mk(1'b0, 1'b1, 4'd4, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd8, 8'h10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0));
    exp_q.push_back(idle_v);
    for (int c = 0; c < 7; c++) begin
      if (c == 0)                drive(1'b1, 1'b0, 16'h3900);
      else if (c == 2 || c == 3) drive(1'b0, 1'b1, 16'hFFFF);
      else                       drive(1'b0, 1'b0, 16'h0000);
      #1;
      if (bus.busy === 1'b1) busy_n++;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL sub_hold c%0d: got %05h required %05h", c, obs, e);
      end
      @(posedge clock);
      #1;
    end
    n_tests++;
    if (busy_n !== 5) begin
      n_fail++;
      $display("FAIL sub_busy_cycles: got %0d required 5", busy_n);
    end
  endtask

  task automatic test_hold_idle();
    logic [19:0] e;
    exp_q.push_back(mk(1'b0, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(idle_v);
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(1'b1, 1'b1, 16'h0280);
      else       drive(1'b0, 1'b0, 16'h0000);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL hold_idle c%0d: got %05h required %05h", c, obs, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_illegal();
    // {ready, busy, gpr_wen, a_wen, r_wen, done, illegal}
    logic [13:0] got;
    logic [13:0] want;
    drive(1'b1, 1'b0, 16'hA600);
    #1;
    n_tests++;
    if (obs !== idle_v) begin
      n_fail++;
      $display("FAIL illegal_pre: got %05h required %05h", obs, idle_v);
    end
    @(posedge clock);
    #1 drive(1'b0, 1'b0, 16'h0000);
    #1;
    got  = {bus.instr_ready, bus.busy, bus.gpr_wen, bus.a_wen, bus.r_wen, bus.done, bus.illegal};
    want = {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL illegal_pulse: got %04h required %04h", got, want);
    end
    @(posedge clock);
    #2;
    n_tests++;
    if (obs !== idle_v) begin
      n_fail++;
      $display("FAIL illegal_post: got %05h required %05h", obs, idle_v);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back_mv();
    logic [2:0]  rx_l[3] = '{3'd0, 3'd2, 3'd6};
    logic [2:0]  ry_l[3] = '{3'd7, 3'd3, 3'd1};
    logic [11:0] w;
    logic [11:0] g;
    logic        want_rdy;
    int          done_n = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) begin
        drive(1'b0, 1'b0, 16'h0000);
      end else if ((c % 2) == 0) begin
        drive(1'b1, 1'b0, {4'h0, rx_l[c/2], ry_l[c/2], 6'b0});
        wb_q.push_back({1'b0, ry_l[c/2], 8'h01 << rx_l[c/2]});
      end else begin
        // A different instruction presented during T1 must not be latched
        drive(1'b1, 1'b0, 16'h5FFF);
      end
      #1;
      want_rdy = ((c % 2) == 0);
      n_tests++;
      if (bus.instr_ready !== want_rdy) begin
        n_fail++;
        $display("FAIL stream_ready c%0d: got %b required %b", c, bus.instr_ready, want_rdy);
      end
      if (bus.done === 1'b1) begin
        done_n++;
        g = {bus.bus_src, bus.gpr_wen};
        n_tests++;
        if (wb_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_wb c%0d: got %03h required none", c, g);
        end else begin
          w = wb_q.pop_front();
          if (g !== w) begin
            n_fail++;
            $display("FAIL stream_wb c%0d: got %03h required %03h", c, g, w);
          end
        end
      end
      @(posedge clock);
      #1;
    end
    n_tests++;
    if (done_n !== 3) begin
      n_fail++;
      $display("FAIL stream_done_count: got %0d required 3", done_n);
    end
    n_tests++;
    if (wb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stream_pending: got %0d required 0", wb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] e;
    exp_q.push_back(idle_v);
    exp_q.push_back(mk(1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 4'd6, 8'h00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0));
    gw_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 1'b0, 16'h5B80);
      else        drive(1'b0, 1'b0, 16'h0000);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %05h required %05h", c, obs, e);
      end
      if (c < 2) begin
        @(posedge clock);
        #1;
      end
    end
    watch_gw = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== idle_v) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %05h required %05h", obs, idle_v);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (obs !== idle_v) begin
        n_fail++;
        $display("FAIL reset_mid_after c%0d: got %05h required %05h", c, obs, idle_v);
      end
      @(posedge clock);
      #1;
    end
    watch_gw = 1'b0;
    n_tests++;
    if (gw_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_writeback: got %b required 0", gw_seen);
    end
  endtask

  initial begin
    idle_v = mk(1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_mvi();
    test_add();
    test_sub_hold();
    test_hold_idle();
    test_illegal();
    test_back_to_back_mv();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
